generador_fecha: RTL and testbench

GENERADOR_FECHA -- requirements
Module: generador_fecha

---
 rtl/fecha_pkg.sv | 23 ++
 rtl/generador_fecha_if.sv | 31 +++
 rtl/dias_mes.sv | 32 +++
 rtl/generador_fecha.sv | 128 ++++++++++++
 tb/tb_generador_fecha.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fecha_pkg.sv
// Shared widths, month lengths and result codes for the reference date
// generator and the date comparator that consumes diaRef/mesRef.
package fecha_pkg;

  localparam int DIA_W = 5;
  localparam int MES_W = 4;

  localparam logic [DIA_W-1:0] LEN_31  = 5'd31;
  localparam logic [DIA_W-1:0] LEN_30  = 5'd30;
  localparam logic [DIA_W-1:0] LEN_FEB = 5'd28;

  typedef enum logic [1:0] {
    CMP_INVALIDO = 2'b00,
    CMP_VENCIDO  = 2'b01,
    CMP_VALIDO   = 2'b10
  } cmp_res_e;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSA = 1'b1
  } estado_e;

endpackage

// File: rtl/generador_fecha_if.sv
// Tick, load request and date/pulse outputs of generador_fecha.
// master drives stimulus, slave is the date generator.
interface generador_fecha_if
  import fecha_pkg::*;
  ;
  logic             tick_in;
  logic             en;
  logic             load_vld;
  logic [DIA_W-1:0] load_dia;
  logic [MES_W-1:0] load_mes;
  logic [DIA_W-1:0] diaRef;
  logic [MES_W-1:0] mesRef;
  logic             load_ack;
  logic             load_err;
  logic             fin_anio;

  modport master (
    output tick_in, en, load_vld,
    output load_dia, load_mes,
    input  diaRef, mesRef,
    input  load_ack, load_err, fin_anio
  );

  modport slave (
    input  tick_in, en, load_vld,
    input  load_dia, load_mes,
    output diaRef, mesRef,
    output load_ack, load_err, fin_anio
  );

endinterface

// File: rtl/dias_mes.sv
// Month length for calendar year 2021 (non-leap).
// Returns 0 for months outside 1..12.
module dias_mes
  import fecha_pkg::*;
(
  input  logic [MES_W-1:0] mes,
  output logic [DIA_W-1:0] len
);

  logic es_valido;
  logic es_feb;
  logic es_30;
  logic es_31;

  assign es_valido = (mes >= 4'd1) && (mes <= 4'd12);
  assign es_feb    = (mes == 4'd2);
  assign es_30     = (mes == 4'd4) || (mes == 4'd6) ||
                     (mes == 4'd9) || (mes == 4'd11);
  assign es_31     = es_valido && !es_feb && !es_30;

  // decode month class into its length
  always_comb begin
    len = '0;
    unique case (1'b1)
      es_feb:  len = LEN_FEB;
      es_30:   len = LEN_30;
      es_31:   len = LEN_31;
      default: len = '0;
    endcase
  end

endmodule

// File: rtl/generador_fecha.sv
// Reference date generator: prescaled day counter over year 2021
// with validated date load, run/pause control and year-end pulse.
module generador_fecha
  import fecha_pkg::*;
#(
  parameter int TICKS_POR_DIA = 4
) (
  input logic clk,
  input logic rst_n,
  generador_fecha_if.slave bus
);

  localparam logic [7:0] PRE_MAX = 8'(TICKS_POR_DIA - 1);

  estado_e          estado_q, estado_d;
  logic [7:0]       presc_q, presc_d;
  logic [DIA_W-1:0] dia_q, dia_d;
  logic [MES_W-1:0] mes_q, mes_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             fin_q, fin_d;

  logic [DIA_W-1:0] len_act;
  logic [DIA_W-1:0] len_load;
  logic             load_ok;
  logic             corre;
  logic             fin_mes;

  dias_mes u_len_act (
    .mes (mes_q),
    .len (len_act)
  );

  dias_mes u_len_load (
    .mes (bus.load_mes),
    .len (len_load)
  );

  assign load_ok = (len_load != '0) &&
                   (bus.load_dia != '0) &&
                   (bus.load_dia <= len_load);

  assign fin_mes = (dia_q >= len_act);

  // run/pause state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= RUN;
    else        estado_q <= estado_d;
  end

  // next state, prescaler, date advance and load handling
  always_comb begin
    estado_d = estado_q;
    presc_d  = presc_q;
    dia_d    = dia_q;
    mes_d    = mes_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    fin_d    = 1'b0;
    corre    = 1'b0;

    unique case (estado_q)
      RUN: begin
        corre = bus.en;
        if (!bus.en) estado_d = PAUSA;
      end
      PAUSA: begin
        corre = bus.en;
        if (bus.en) estado_d = RUN;
      end
      default: estado_d = RUN;
    endcase

    if (bus.load_vld && load_ok) begin
      dia_d   = bus.load_dia;
      mes_d   = bus.load_mes;
      presc_d = '0;
      ack_d   = 1'b1;
    end else begin
      err_d = bus.load_vld;
      if (corre && bus.tick_in) begin
        if (presc_q == PRE_MAX) begin
          presc_d = '0;
          unique case (1'b1)
            !fin_mes: dia_d = dia_q + 5'd1;
            fin_mes && (mes_q < 4'd12): begin
              dia_d = 5'd1;
              mes_d = mes_q + 4'd1;
            end
            default: begin
              dia_d = 5'd1;
              mes_d = 4'd1;
              fin_d = 1'b1;
            end
          endcase
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
    end
  end

  // date, prescaler and output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      dia_q   <= 5'd1;
      mes_q   <= 4'd1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dia_q   <= dia_d;
      mes_q   <= mes_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.diaRef   = dia_q;
  assign bus.mesRef   = mes_q;
  assign bus.load_ack = ack_q;
  assign bus.load_err = err_q;
  assign bus.fin_anio = fin_q;

endmodule

// File: tb/tb_generador_fecha.sv
// Directed bench for generador_fecha: expected pulses go into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_generador_fecha;
  import fecha_pkg::*;

  typedef struct packed {
    logic       ack;
    logic       err;
    logic       fin;
    logic [4:0] dia;
    logic [3:0] mes;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  ev_t  sb[$];

  always #5 clk = ~clk;

  generador_fecha_if bus ();

  generador_fecha #(.TICKS_POR_DIA(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // pulse monitor
  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (bus.load_ack || bus.load_err || bus.fin_anio) begin
      got = {bus.load_ack, bus.load_err, bus.fin_anio,
             bus.diaRef, bus.mesRef};
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse: unexpected ack=%0b err=%0b fin=%0b at %0d/%0d",
                 got.ack, got.err, got.fin, got.dia, got.mes);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pulse: got ack=%0b err=%0b fin=%0b %0d/%0d, expected ack=%0b err=%0b fin=%0b %0d/%0d",
                   got.ack, got.err, got.fin, got.dia, got.mes,
                   exp.ack, exp.err, exp.fin, exp.dia, exp.mes);
        end
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick_in = 1'b1;
      @(posedge clk);
      #1;
      bus.tick_in = 1'b0;
    end
  endtask

  task automatic load(input int d, input int m, input logic tk,
                      input logic ok, input int ed, input int em);
    ev_t e;
    e = {ok, !ok, 1'b0, 5'(ed), 4'(em)};
    sb.push_back(e);
    bus.load_vld = 1'b1;
    bus.load_dia = 5'(d);
    bus.load_mes = 4'(m);
    bus.tick_in  = tk;
    @(posedge clk);
    #1;
    bus.load_vld = 1'b0;
    bus.tick_in  = 1'b0;
  endtask

  task automatic chk(input string name, input int d, input int m);
    @(negedge clk);
    vectors++;
    if (bus.diaRef !== 5'(d) || bus.mesRef !== 4'(m)) begin
      errors++;
      $display("FAIL %s: got %0d/%0d expected %0d/%0d",
               name, bus.diaRef, bus.mesRef, d, m);
    end
  endtask

  initial begin
    ev_t f;
    bus.tick_in  = 1'b0;
    bus.en       = 1'b1;
    bus.load_vld = 1'b0;
    bus.load_dia = '0;
    bus.load_mes = '0;

    chk("reset", 1, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    ticks(3);
    chk("3 ticks", 1, 1);
    ticks(1);
    chk("4th tick", 2, 1);

    load(28, 2, 1'b0, 1'b1, 28, 2);
    chk("load 28/2", 28, 2);
    ticks(4);
    chk("feb end", 1, 3);

    load(31, 12, 1'b0, 1'b1, 31, 12);
    ticks(3);
    f = {1'b0, 1'b0, 1'b1, 5'd1, 4'd1};
    sb.push_back(f);
    ticks(1);
    chk("year end", 1, 1);

    load(29, 2, 1'b0, 1'b0, 1, 1);
    load(31, 4, 1'b0, 1'b0, 1, 1);
    load(0, 5, 1'b0, 1'b0, 1, 1);
    load(10, 13, 1'b0, 1'b0, 1, 1);
    chk("bad loads", 1, 1);

    ticks(3);
    load(15, 6, 1'b1, 1'b1, 15, 6);
    chk("load+tick", 15, 6);
    ticks(3);
    chk("presc cleared", 15, 6);
    ticks(1);
    chk("16/6", 16, 6);

    ticks(3);
    load(31, 6, 1'b1, 1'b0, 17, 6);
    chk("bad load+tick", 17, 6);

    load(30, 6, 1'b0, 1'b1, 30, 6);
    ticks(4);
    chk("june end", 1, 7);

    bus.en = 1'b0;
    ticks(10);
    chk("paused", 1, 7);
    load(5, 8, 1'b0, 1'b1, 5, 8);
    chk("load paused", 5, 8);

    bus.en = 1'b1;
    ticks(2);
    bus.en = 1'b0;
    ticks(5);
    bus.en = 1'b1;
    ticks(1);
    chk("presc held", 5, 8);
    ticks(1);
    chk("resume", 6, 8);

    ticks(3);
    bus.en = 1'b0;
    ticks(2);
    bus.en       = 1'b1;
    bus.load_vld = 1'b1;
    bus.load_dia = 5'd10;
    bus.load_mes = 4'd10;
    bus.tick_in  = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    bus.load_vld = 1'b0;
    bus.tick_in  = 1'b0;
    chk("mid reset", 1, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ticks(3);
    chk("post reset 3", 1, 1);
    ticks(1);
    chk("post reset 4", 2, 1);

    repeat (3) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d pulses missing, expected 0",
               sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
